// File: rtl/sim_cmp_pkg.sv
// Payload layout definitions shared by the stimulus driver and the result batch collector.
package sim_cmp_pkg;

    localparam int DEFAULT_ITEM_WIDTH = 8;
    localparam int DEFAULT_NUM        = 1000;

    typedef logic [DEFAULT_ITEM_WIDTH-1:0] item_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != '1)) begin
            q_reg <= q_reg + W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/res_batch_collector.sv
// Packs NUM result items into a flat batch handed off with valid/ready.
// Optional checksum output enabled by defining RES_BATCH_COLLECTOR_CHECKSUM_EN.
module res_batch_collector
    import sim_cmp_pkg::*;
#(
    parameter int NUM        = DEFAULT_NUM,
    parameter int ITEM_WIDTH = DEFAULT_ITEM_WIDTH,
    parameter int DROP_W     = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [ITEM_WIDTH-1:0]     res_i,
    input  logic                      res_valid_i,
    output logic [NUM*ITEM_WIDTH-1:0] batch_o,
    output logic                      batch_valid_o,
    input  logic                      batch_ready_i,
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
    output logic [ITEM_WIDTH+$clog2(NUM)-1:0] checksum_o,
`endif
    output logic [$clog2(NUM+1)-1:0]  fill_cnt_o,
    output logic [DROP_W-1:0]         drop_cnt_o,
    output logic                      overflow_o
);

    localparam int PTR_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int CNT_W = $clog2(NUM+1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM-1);

    state_t                  state_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [CNT_W-1:0]        fill_reg;
    logic                    batch_valid_reg;
    logic                    overflow_reg;
    logic [ITEM_WIDTH-1:0]   slot_reg [NUM];
    logic [NUM-1:0]          slot_we;

    logic                    handshake;
    logic                    accept;
    logic                    drop;
    logic [PTR_W-1:0]        slot;
    logic                    last;

    // A handshake frees the buffer in the same cycle, so a concurrent item lands in slot 0.
    assign handshake = batch_valid_reg && batch_ready_i;
    assign accept    = res_valid_i && ((state_reg == FILL) || handshake);
    assign drop      = res_valid_i && (state_reg == HOLD) && !handshake;
    assign slot      = handshake ? '0 : wr_ptr_reg;
    assign last      = (slot == LAST_PTR);

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_slot
            assign slot_we[gi] = accept && (slot == PTR_W'(gi));
            assign batch_o[gi*ITEM_WIDTH +: ITEM_WIDTH] = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM; i++) begin
            if (!reset_i) begin
                slot_reg[i] <= '0;
            end else if (slot_we[i]) begin
                slot_reg[i] <= res_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_reg       <= FILL;
            wr_ptr_reg      <= '0;
            fill_reg        <= '0;
            batch_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (handshake) begin
                state_reg       <= FILL;
                batch_valid_reg <= 1'b0;
                fill_reg        <= '0;
            end
            if (accept) begin
                fill_reg <= CNT_W'(slot) + CNT_W'(1);
                if (last) begin
                    state_reg       <= HOLD;
                    batch_valid_reg <= 1'b1;
                    wr_ptr_reg      <= '0;
                end else begin
                    wr_ptr_reg <= slot + PTR_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk (clk_i),
        .clr (!reset_i),
        .inc (drop),
        .q   (drop_cnt_o)
    );

`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
    localparam int SUM_W = ITEM_WIDTH + $clog2(NUM);
    logic [SUM_W-1:0] sum_reg;

    // The first write of a batch restarts the sum instead of adding to the old one.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sum_reg <= '0;
        end else if (accept) begin
            sum_reg <= ((slot == '0) ? '0 : sum_reg) + SUM_W'(res_i);
        end
    end

    assign checksum_o = sum_reg;
`endif

    assign batch_valid_o = batch_valid_reg;
    assign fill_cnt_o    = fill_reg;
    assign overflow_o    = overflow_reg;

endmodule

// File: tb/tb_res_batch_collector.sv
// Directed self-checking bench for res_batch_collector with NUM=4, ITEM_WIDTH=8.
module tb_res_batch_collector;

    localparam int NUM    = 4;
    localparam int IW     = 8;
    localparam int DROP_W = 16;

    logic              clk;
    logic              reset_i;
    logic [IW-1:0]     res_i;
    logic              res_valid_i;
    logic [NUM*IW-1:0] batch_o;
    logic              batch_valid_o;
    logic              batch_ready_i;
    logic [2:0]        fill_cnt_o;
    logic [DROP_W-1:0] drop_cnt_o;
    logic              overflow_o;
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
    logic [9:0]        checksum_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    res_batch_collector #(
        .NUM        (NUM),
        .ITEM_WIDTH (IW),
        .DROP_W     (DROP_W)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .res_i         (res_i),
        .res_valid_i   (res_valid_i),
        .batch_o       (batch_o),
        .batch_valid_o (batch_valid_o),
        .batch_ready_i (batch_ready_i),
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
        .checksum_o    (checksum_o),
`endif
        .fill_cnt_o    (fill_cnt_o),
        .drop_cnt_o    (drop_cnt_o),
        .overflow_o    (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs set before step() are sampled at the next posedge; outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [IW-1:0] item);
        res_i       = item;
        res_valid_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        $display("item %02h ready=%0b -> valid=%0b fill=%0d drop=%0d", item, batch_ready_i,
                 batch_valid_o, fill_cnt_o, drop_cnt_o);
    endtask

    task automatic test_reset();
        reset_i       = 1'b0;
        res_i         = '0;
        res_valid_i   = 1'b0;
        batch_ready_i = 1'b0;
        step();
        step();
        n_checks++;
        if (batch_o !== '0) begin n_fail++; $display("FAIL reset_batch: got %h want 0", batch_o); end
        n_checks++;
        if (batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", batch_valid_o); end
        n_checks++;
        if (fill_cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_cnt_o); end
        n_checks++;
        if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
        n_checks++;
        if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        reset_i = 1'b1;
        step();
    endtask

    task automatic test_fill();
        feed(8'h11);
        feed(8'h22);
        feed(8'h33);
        n_checks++;
        if (batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid: got %b want 0", batch_valid_o); end
        n_checks++;
        if (fill_cnt_o !== 3'd3) begin n_fail++; $display("FAIL fill_cnt3: got %0d want 3", fill_cnt_o); end
        feed(8'h44);
        n_checks++;
        if (batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b want 1", batch_valid_o); end
        n_checks++;
        if (batch_o !== 32'h44332211) begin n_fail++; $display("FAIL fill_batch: got %h want 44332211", batch_o); end
        n_checks++;
        if (fill_cnt_o !== 3'd4) begin n_fail++; $display("FAIL fill_cnt4: got %0d want 4", fill_cnt_o); end
    endtask

    task automatic test_drop();
        feed(8'h55);
        feed(8'h66);
        feed(8'h77);
        n_checks++;
        if (drop_cnt_o !== 16'd3) begin n_fail++; $display("FAIL drop_cnt: got %0d want 3", drop_cnt_o); end
        n_checks++;
        if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %b want 1", overflow_o); end
        n_checks++;
        if (batch_o !== 32'h44332211) begin n_fail++; $display("FAIL drop_batch_stable: got %h want 44332211", batch_o); end
        n_checks++;
        if (batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL drop_valid_held: got %b want 1", batch_valid_o); end
        batch_ready_i = 1'b1;
        step();
        batch_ready_i = 1'b0;
        n_checks++;
        if (batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL hs_valid: got %b want 0", batch_valid_o); end
        n_checks++;
        if (fill_cnt_o !== 3'd0) begin n_fail++; $display("FAIL hs_fill: got %0d want 0", fill_cnt_o); end
        n_checks++;
        if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL hs_overflow_sticky: got %b want 1", overflow_o); end
        n_checks++;
        if (drop_cnt_o !== 16'd3) begin n_fail++; $display("FAIL hs_drop: got %0d want 3", drop_cnt_o); end
    endtask

    task automatic test_handshake_write();
        feed(8'h01);
        feed(8'h02);
        feed(8'h03);
        feed(8'h04);
        n_checks++;
        if (batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL hsw_valid: got %b want 1", batch_valid_o); end
        batch_ready_i = 1'b1;
        feed(8'hAA);
        batch_ready_i = 1'b0;
        n_checks++;
        if (batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL hsw_valid_clear: got %b want 0", batch_valid_o); end
        n_checks++;
        if (fill_cnt_o !== 3'd1) begin n_fail++; $display("FAIL hsw_fill: got %0d want 1", fill_cnt_o); end
        n_checks++;
        if (batch_o !== 32'h040302AA) begin n_fail++; $display("FAIL hsw_batch: got %h want 040302aa", batch_o); end
        n_checks++;
        if (drop_cnt_o !== 16'd3) begin n_fail++; $display("FAIL hsw_drop: got %0d want 3", drop_cnt_o); end
    endtask

    task automatic test_gapped();
        int pulses;
        logic [31:0] want_batch;
        reset_i = 1'b0;
        step();
        reset_i       = 1'b1;
        batch_ready_i = 1'b1;
        pulses        = 0;
        for (int i = 0; i < 8; i++) begin
            feed(8'(i + 1));
            n_checks++;
            if (batch_valid_o !== ((i % 4) == 3)) begin
                n_fail++;
                $display("FAIL gap_valid_item%0d: got %b want %b", i, batch_valid_o, ((i % 4) == 3));
            end
            if (batch_valid_o === 1'b1) begin
                pulses++;
                want_batch = (i == 3) ? 32'h04030201 : 32'h08070605;
                n_checks++;
                if (batch_o !== want_batch) begin
                    n_fail++;
                    $display("FAIL gap_batch_item%0d: got %h want %h", i, batch_o, want_batch);
                end
            end
            for (int k = 0; k < 2; k++) begin
                step();
                n_checks++;
                if (batch_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_idle_valid_item%0d: got %b want 0", i, batch_valid_o);
                end
            end
        end
        batch_ready_i = 1'b0;
        n_checks++;
        if (pulses != 2) begin n_fail++; $display("FAIL gap_pulses: got %0d want 2", pulses); end
        n_checks++;
        if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL gap_drop: got %0d want 0", drop_cnt_o); end
        n_checks++;
        if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL gap_overflow: got %b want 0", overflow_o); end
    endtask

    task automatic test_reset_mid();
        feed(8'hC1);
        feed(8'hC2);
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        n_checks++;
        if (batch_o !== '0) begin n_fail++; $display("FAIL mid_batch: got %h want 0", batch_o); end
        n_checks++;
        if (fill_cnt_o !== 3'd0) begin n_fail++; $display("FAIL mid_fill: got %0d want 0", fill_cnt_o); end
        n_checks++;
        if (batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", batch_valid_o); end
        feed(8'hD1);
        feed(8'hD2);
        feed(8'hD3);
        feed(8'hD4);
        n_checks++;
        if (batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_after_valid: got %b want 1", batch_valid_o); end
        n_checks++;
        if (batch_o !== 32'hD4D3D2D1) begin n_fail++; $display("FAIL mid_after_batch: got %h want d4d3d2d1", batch_o); end
        n_checks++;
        if (fill_cnt_o !== 3'd4) begin n_fail++; $display("FAIL mid_after_fill: got %0d want 4", fill_cnt_o); end
    endtask

`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
    task automatic test_checksum();
        batch_ready_i = 1'b1;
        step();
        batch_ready_i = 1'b0;
        feed(8'hFF);
        feed(8'hFF);
        feed(8'hFF);
        feed(8'h01);
        n_checks++;
        if (batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL csum_valid: got %b want 1", batch_valid_o); end
        n_checks++;
        if (checksum_o !== 10'h2FE) begin n_fail++; $display("FAIL csum_value: got %h want 2fe", checksum_o); end
        feed(8'h10);
        n_checks++;
        if (checksum_o !== 10'h2FE) begin n_fail++; $display("FAIL csum_drop_ignored: got %h want 2fe", checksum_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drop();
        test_handshake_write();
        test_gapped();
        test_reset_mid();
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/res_batch_collector.md
Name: res_batch_collector

Overview:
- Receive-side counterpart of the stimulus driver: captures the DUT result stream (res_o of bfm) one item per valid cycle.
- Packs NUM consecutive items into a flat batch register and presents it to the testbench/DPI consumer with a valid/ready handshake.
- Mirrors the driver's packed payload layout so the batch can be returned through a single DPI call.

Parameters:
- NUM, 1000, items per batch
- ITEM_WIDTH, 8, bits per item
- DROP_W, 16, width of saturating drop counter

Ports:
- clk_i  in  1  clock; all logic on posedge
- reset_i  in  1  synchronous reset, active-low
- res_i  in  ITEM_WIDTH  result item from DUT
- res_valid_i  in  1  res_i valid this cycle
- batch_o  out  NUM*ITEM_WIDTH  packed batch; item k at bits [k*ITEM_WIDTH +: ITEM_WIDTH]
- batch_valid_o  out  1  batch_o complete and stable
- batch_ready_i  in  1  consumer accepts batch
- fill_cnt_o  out  $clog2(NUM+1)  items held in current batch
- drop_cnt_o  out  DROP_W  items discarded while batch held, saturating
- overflow_o  out  1  sticky; set on first drop

Behaviour:
- Reset (reset_i==0 at posedge): state FILL, wr_ptr=0, batch_o=0, batch_valid_o=0, fill_cnt_o=0, drop_cnt_o=0, overflow_o=0. Takes priority over every other event; a held batch is discarded.
- States: FILL, HOLD.
- FILL + res_valid_i:
  - write res_i to slot wr_ptr; wr_ptr++, fill_cnt_o++.
  - if wr_ptr==NUM-1: next state HOLD, batch_valid_o=1 next cycle, wr_ptr wraps to 0.
  - Latency: last item to batch_valid_o = 1 cycle.
- FILL, no res_valid_i: hold.
- HOLD:
  - batch_o and batch_valid_o stable until handshake; fill_cnt_o==NUM.
  - res_valid_i without handshake: item dropped; drop_cnt_o++ (saturates at 2^DROP_W-1); overflow_o=1 sticky.
- Handshake (batch_valid_o && batch_ready_i at posedge):
  - batch_valid_o=0, state FILL, fill_cnt_o=0.
  - Same-cycle res_valid_i: item written to slot 0 (not dropped); wr_ptr=1, fill_cnt_o=1.
- batch_ready_i while batch_valid_o=0: ignored.
- Slots not yet rewritten keep stale data from the previous batch; only valid under batch_valid_o.
- NUM==1: every valid item completes a batch.

Optional Feature:
- Macro: RES_BATCH_COLLECTOR_CHECKSUM_EN
- Defined:
  - adds output checksum_o, ITEM_WIDTH+$clog2(NUM) bits: modular sum of all items in the current batch.
  - Cleared at reset and at the first write of each batch.
  - Valid and stable while batch_valid_o=1.
  - Dropped items are not summed.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Shared package sim_cmp_pkg:
  - ITEM_WIDTH default, NUM default
  - typedef item_t (logic [ITEM_WIDTH-1:0])
  - state enum {FILL, HOLD}
  - Same package the stimulus driver uses for payload layout.
- Sub-module: sat_counter (parameter W; inc, clr, q), used for drop_cnt_o. The checksum accumulator stays inline.

Test Plan (NUM=4, ITEM_WIDTH=8):
- Items 0x11,0x22,0x33,0x44 on consecutive cycles, batch_ready_i=0 -> batch_valid_o=1 one cycle after 0x44; batch_o=0x44332211; fill_cnt_o=4.
- Held batch, 3 more valid items, then ready -> drop_cnt_o=3, overflow_o=1, batch_o unchanged; after handshake batch_valid_o=0, fill_cnt_o=0, overflow_o still 1.
- Handshake cycle with res_valid_i and res_i=0xAA -> next cycle fill_cnt_o=1, slot0=0xAA, drop_cnt_o unchanged.
- Gapped input (valid every third cycle) with ready held high -> batch_valid_o pulses exactly one cycle per 4 items; no drops.
- reset_i=0 for one cycle after 2 items -> all outputs zero; the next 4 items form a complete batch starting at slot 0.
- CHECKSUM_EN defined, items 0xFF,0xFF,0xFF,0x01 -> checksum_o=0x2FE (10 bits) while batch_valid_o=1.
